// File: rtl/fme_pkg.sv
// Shared scheduler state encodings and default per-block phase lengths for the
// fractional-ME interpolation scheduler.
package fme_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_BEGIN  = 3'd2,
        ST_PH     = 3'd3,
        ST_SETUP  = 3'd4,
        ST_PVPO   = 3'd5,
        ST_PVSO   = 3'd6,
        ST_DONE   = 3'd7
    } sched_state_t;

    localparam int DEF_PH_CYCLES   = 16;
    localparam int DEF_PVPO_CYCLES = 7;
    localparam int DEF_PVSO_CYCLES = 27;
    localparam int DEF_CNT_W       = 5;
    localparam int DEF_NB_W        = 4;

endpackage

// File: rtl/fme_phase_counter.sv
// Shared phase-length counter: clears or increments, and flags when the count
// reaches a runtime-selected terminal value.
module fme_phase_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == limit);

endmodule

// File: rtl/fme_interpolation_scheduler.sv
// Batch sequencer that mirrors interpolation_control phase by phase and emits
// the enable launch pulse and per-phase finished pulses for N blocks.
module fme_interpolation_scheduler
    import fme_pkg::*;
#(
    parameter int PH_CYCLES   = DEF_PH_CYCLES,
    parameter int PVPO_CYCLES = DEF_PVPO_CYCLES,
    parameter int PVSO_CYCLES = DEF_PVSO_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int NB_W        = DEF_NB_W
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [NB_W-1:0] num_blocks,
    output logic            enable,
    output logic            PH_INTERPOLATION_finished,
    output logic            PVPO_INTERPOLATION_finished,
    output logic            PVSO_INTERPOLATION_finished,
    output logic [NB_W-1:0] block_index,
    output logic [2:0]      phase,
    output logic            busy,
    output logic            done
);

    sched_state_t    state;
    logic [NB_W-1:0] block_idx_q;
    logic [NB_W-1:0] latched_n;

    logic             counting;
    logic             cnt_clear;
    logic             terminal;
    logic [CNT_W-1:0] limit;
    logic             last_block;

    // The single counter runs only inside the three timed phases and is
    // cleared on the terminal cycle so the next phase always starts at zero.
    always_comb begin
        limit = '0;
        case (state)
            ST_PH:   limit = CNT_W'(PH_CYCLES - 1);
            ST_PVPO: limit = CNT_W'(PVPO_CYCLES - 1);
            ST_PVSO: limit = CNT_W'(PVSO_CYCLES - 1);
            default: limit = '0;
        endcase
    end

    assign counting   = (state == ST_PH) || (state == ST_PVPO) || (state == ST_PVSO);
    assign cnt_clear  = !counting || terminal;
    assign last_block = (block_idx_q == (latched_n - NB_W'(1)));

    fme_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .inc      (counting),
        .limit    (limit),
        .terminal (terminal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            block_idx_q <= '0;
            latched_n   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_blocks != '0) begin
                            latched_n   <= num_blocks;
                            block_idx_q <= '0;
                            state       <= ST_LAUNCH;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LAUNCH: state <= ST_BEGIN;
                ST_BEGIN:  state <= ST_PH;
                ST_PH: begin
                    if (terminal) state <= ST_SETUP;
                end
                ST_SETUP:  state <= ST_PVPO;
                ST_PVPO: begin
                    if (terminal) state <= ST_PVSO;
                end
                ST_PVSO: begin
                    if (terminal) begin
                        if (last_block) begin
                            state <= ST_DONE;
                        end else begin
                            block_idx_q <= block_idx_q + NB_W'(1);
                            state       <= ST_LAUNCH;
                        end
                    end
                end
                ST_DONE: begin
                    block_idx_q <= '0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; nothing flows through from start.
    assign enable                      = (state == ST_LAUNCH);
    assign PH_INTERPOLATION_finished   = (state == ST_PH)   && terminal;
    assign PVPO_INTERPOLATION_finished = (state == ST_PVPO) && terminal;
    assign PVSO_INTERPOLATION_finished = (state == ST_PVSO) && terminal;
    assign block_index                 = block_idx_q;
    assign phase                       = state;
    assign busy                        = (state != ST_IDLE);
    assign done                        = (state == ST_DONE);

endmodule
